// File: rtl/conv2d_layer_sequencer.sv
// conv2d_layer_sequencer: walks oc (outer) / ic (middle) / row (inner) and issues PE-engine strobes.
// Latency: start -> Load_kernel_reg 1 cycle; final Done_1row -> layer_done 3 cycles when PE is idle.
// Backpressure: stalls in WAIT_K / WAIT_PE / WAIT_ROW / DRAIN until the matching handshake is high.
// Build option: define CONV_SEQ_PERF_EN to build the saturating busy_cycles counter (else tied to 0).
module conv2d_layer_sequencer #(
   parameter int DIM_WIDTH = 10,
   parameter int CH_WIDTH  = 8   // also the b_counter_output width
) (
   input  logic                 clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [DIM_WIDTH-1:0] cfg_height,
   input  logic [CH_WIDTH-1:0]  cfg_in_ch,
   input  logic [CH_WIDTH-1:0]  cfg_out_ch,
   input  logic                 kernel_ready,
   input  logic                 Done_1row,
   input  logic                 PE_ready,
   input  logic                 PE_with_buffers_IDLE,
   output logic                 Load_kernel_reg,
   output logic                 row_start,
   output logic                 Stream_mid_row,
   output logic                 Stream_last_row,
   output logic                 last_channel,
   output logic [CH_WIDTH-1:0]  b_counter_output,
   output logic                 busy,
   output logic                 layer_done,
   output logic                 cfg_error,
   output logic [31:0]          busy_cycles
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_K, S_WAIT_K, S_WAIT_PE, S_ROW,
      S_WAIT_ROW, S_NEXT_IC, S_DRAIN, S_DONE
   } state_t;

   state_t               state;
   logic [DIM_WIDTH-1:0] h_q, row;
   logic [CH_WIDTH-1:0]  ci_q, co_q, ic, oc;

   logic                 cfg_zero, start_accept;
   logic [DIM_WIDTH-1:0] h_last, row_inc;
   logic [CH_WIDTH-1:0]  ci_last, co_last, ic_inc, oc_inc;

   // Any zero dimension makes the layer meaningless, so such a start is rejected.
   assign cfg_zero     = (cfg_height == '0) || (cfg_in_ch == '0) || (cfg_out_ch == '0);
   assign start_accept = (state == S_IDLE) && start && !cfg_zero;

   // Loop bounds always come from the latched copies, so cfg inputs may change mid-layer.
   assign h_last  = h_q  - DIM_WIDTH'(1);
   assign ci_last = ci_q - CH_WIDTH'(1);
   assign co_last = co_q - CH_WIDTH'(1);
   assign row_inc = row + DIM_WIDTH'(1);
   assign ic_inc  = ic  + CH_WIDTH'(1);
   assign oc_inc  = oc  + CH_WIDTH'(1);

   assign b_counter_output = oc;

   // Sequencer FSM; row/ic level flags are written from the value the counter is about to take.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state           <= S_IDLE;
         h_q             <= '0;
         ci_q            <= '0;
         co_q            <= '0;
         row             <= '0;
         ic              <= '0;
         oc              <= '0;
         Load_kernel_reg <= 1'b0;
         row_start       <= 1'b0;
         Stream_mid_row  <= 1'b0;
         Stream_last_row <= 1'b0;
         last_channel    <= 1'b0;
         busy            <= 1'b0;
         layer_done      <= 1'b0;
         cfg_error       <= 1'b0;
      end else begin
         Load_kernel_reg <= 1'b0;
         row_start       <= 1'b0;
         layer_done      <= 1'b0;
         cfg_error       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_accept) begin
                  h_q             <= cfg_height;
                  ci_q            <= cfg_in_ch;
                  co_q            <= cfg_out_ch;
                  row             <= '0;
                  ic              <= '0;
                  oc              <= '0;
                  busy            <= 1'b1;
                  Stream_mid_row  <= (cfg_height != DIM_WIDTH'(1));
                  Stream_last_row <= (cfg_height == DIM_WIDTH'(1));
                  last_channel    <= (cfg_in_ch == CH_WIDTH'(1));
                  Load_kernel_reg <= 1'b1;
                  state           <= S_LOAD_K;
               end else if (start) begin
                  cfg_error <= 1'b1;
               end
            end
            S_LOAD_K: state <= S_WAIT_K;
            S_WAIT_K: begin
               if (kernel_ready) state <= S_WAIT_PE;
            end
            S_WAIT_PE: begin
               if (PE_ready) begin
                  row_start <= 1'b1;
                  state     <= S_ROW;
               end
            end
            S_ROW: state <= S_WAIT_ROW;
            S_WAIT_ROW: begin
               if (Done_1row) begin
                  if (row < h_last) begin
                     row             <= row_inc;
                     Stream_mid_row  <= (row_inc != h_last);
                     Stream_last_row <= (row_inc == h_last);
                     state           <= S_WAIT_PE;
                  end else begin
                     row             <= '0;
                     Stream_mid_row  <= (h_last != '0);
                     Stream_last_row <= (h_last == '0);
                     state           <= S_NEXT_IC;
                  end
               end
            end
            S_NEXT_IC: begin
               if (ic < ci_last) begin
                  ic              <= ic_inc;
                  last_channel    <= (ic_inc == ci_last);
                  Load_kernel_reg <= 1'b1;
                  state           <= S_LOAD_K;
               end else begin
                  ic           <= '0;
                  last_channel <= (ci_last == '0);
                  state        <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // oc only moves once the previous channel's output has left the PE.
               if (PE_with_buffers_IDLE) begin
                  if (oc < co_last) begin
                     oc              <= oc_inc;
                     Load_kernel_reg <= 1'b1;
                     state           <= S_LOAD_K;
                  end else begin
                     layer_done      <= 1'b1;
                     busy            <= 1'b0;
                     Stream_mid_row  <= 1'b0;
                     Stream_last_row <= 1'b0;
                     last_channel    <= 1'b0;
                     state           <= S_DONE;
                  end
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CONV_SEQ_PERF_EN
   // Saturating busy-cycle counter: cleared by an accepted start, held while not busy.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         busy_cycles <= '0;
      end else if (start_accept) begin
         busy_cycles <= '0;
      end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
         busy_cycles <= busy_cycles + 32'd1;
      end
   end
`else
   assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Bench for conv2d_layer_sequencer: randomized layers against an event-queue model of the
// oc/ic/row walk, a PE responder with configurable handshake delays, and literal spot checks.
`timescale 1ns/1ps
module tb_conv2d_layer_sequencer;

   localparam int DW = 10;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          Reset = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] cfg_height = '0;
   logic [CW-1:0] cfg_in_ch = '0;
   logic [CW-1:0] cfg_out_ch = '0;
   logic          kernel_ready = 1'b1;
   logic          Done_1row = 1'b0;
   logic          PE_ready = 1'b1;
   logic          PE_with_buffers_IDLE = 1'b1;
   logic          Load_kernel_reg, row_start, Stream_mid_row, Stream_last_row, last_channel;
   logic [CW-1:0] b_counter_output;
   logic          busy, layer_done, cfg_error;
   logic [31:0]   busy_cycles;

   always #5 clk = ~clk;

   conv2d_layer_sequencer #(.DIM_WIDTH(DW), .CH_WIDTH(CW)) dut (
      .clk(clk), .Reset(Reset), .start(start),
      .cfg_height(cfg_height), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
      .kernel_ready(kernel_ready), .Done_1row(Done_1row), .PE_ready(PE_ready),
      .PE_with_buffers_IDLE(PE_with_buffers_IDLE),
      .Load_kernel_reg(Load_kernel_reg), .row_start(row_start),
      .Stream_mid_row(Stream_mid_row), .Stream_last_row(Stream_last_row),
      .last_channel(last_channel), .b_counter_output(b_counter_output),
      .busy(busy), .layer_done(layer_done), .cfg_error(cfg_error),
      .busy_cycles(busy_cycles)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // ---------------- PE / kernel-fetch responder ----------------
   int kdelay = 0, pe_delay = 0, idle_delay = 0, done_delay = 4;
   bit pe_rand = 0, idle_rand = 0, spur_en = 0;
   int k_cnt = 0, pe_cnt = 0, idle_cnt = 0, done_cnt = 0, spur_cnt = 0;

   initial begin
      bit real_done;
      forever begin
         @(posedge clk); #1;
         if (!Reset) begin
            k_cnt = 0; pe_cnt = 0; idle_cnt = 0; done_cnt = 0; spur_cnt = 0;
            Done_1row = 1'b0; kernel_ready = 1'b1; PE_ready = 1'b1; PE_with_buffers_IDLE = 1'b1;
         end else begin
            real_done = 1'b0;
            Done_1row = 1'b0;
            if (done_cnt > 0) begin
               done_cnt--;
               if (done_cnt == 0) begin Done_1row = 1'b1; real_done = 1'b1; end
            end
            if (spur_cnt > 0) begin
               spur_cnt--;
               if (spur_cnt == 0) Done_1row = 1'b1;
            end
            if (row_start) done_cnt = done_delay;
            if (Load_kernel_reg && spur_en) spur_cnt = 1;
            if (k_cnt > 0) begin
               k_cnt--;
               if (k_cnt == 0) kernel_ready = 1'b1;
            end
            if (Load_kernel_reg && kdelay > 0) begin kernel_ready = 1'b0; k_cnt = kdelay; end
            if (pe_cnt > 0) begin
               pe_cnt--;
               if (pe_cnt == 0) PE_ready = 1'b1;
            end
            if ((Load_kernel_reg || real_done) && pe_delay > 0) begin PE_ready = 1'b0; pe_cnt = pe_delay; end
            if (pe_rand && pe_cnt == 0) PE_ready = ($urandom_range(0, 3) != 0);
            if (idle_cnt > 0) begin
               idle_cnt--;
               if (idle_cnt == 0) PE_with_buffers_IDLE = 1'b1;
            end
            if (real_done && idle_delay > 0) begin PE_with_buffers_IDLE = 1'b0; idle_cnt = idle_delay; end
            if (idle_rand && idle_cnt == 0) PE_with_buffers_IDLE = ($urandom_range(0, 2) != 0);
         end
      end
   end

   // ---------------- behavioural model: expected event order ----------------
   typedef struct packed { int oc; int ic; } kev_t;
   typedef struct packed { int oc; int ic; int row; } rev_t;
   kev_t exp_k[$];
   rev_t exp_r[$];
   int   load_oc_log[$];
   int   m_h = 1, m_ci = 1, m_co = 1;
   int   cur_oc = 0;
   bit   kr_ok = 0, prev_pe = 0, prev_idle = 0, outstanding = 0, first_load = 1, lat_en = 0;
   int   n_loads = 0, n_rows = 0, n_done = 0, n_err = 0, busy_cnt = 0, cyc = 0, last_done_cyc = 0;

   // compare process
   initial begin
      kev_t ke;
      rev_t re;
      forever begin
         @(negedge clk);
         cyc++;
         if (!Reset) begin
            outstanding = 0; kr_ok = 0; prev_pe = 0; prev_idle = 0;
         end else begin
            if (busy) busy_cnt++;
            if (cfg_error) n_err++;
            if (Load_kernel_reg) begin
               n_loads++;
               if (exp_k.size() == 0) check_eq("unexpected_load", 1, 0);
               else begin
                  ke = exp_k.pop_front();
                  load_oc_log.push_back(int'(b_counter_output));
                  check_eq("load_oc", b_counter_output, ke.oc);
                  check_eq("load_last_channel", last_channel, (ke.ic == m_ci - 1));
                  check_eq("load_stream_last", Stream_last_row, (m_h == 1));
                  if (!first_load && ke.oc != cur_oc) check_eq("oc_adv_needs_idle", prev_idle, 1);
                  cur_oc = ke.oc;
                  first_load = 0;
               end
               kr_ok = 0;
            end else if (kernel_ready) begin
               kr_ok = 1;
            end
            if (row_start) begin
               n_rows++;
               check_eq("row_needs_kernel", kr_ok, 1);
               check_eq("row_needs_pe_ready", prev_pe, 1);
               if (exp_r.size() == 0) check_eq("unexpected_row", 1, 0);
               else begin
                  re = exp_r.pop_front();
                  check_eq("row_oc", b_counter_output, re.oc);
                  check_eq("row_last_channel", last_channel, (re.ic == m_ci - 1));
                  check_eq("row_stream_last", Stream_last_row, (re.row == m_h - 1));
                  check_eq("row_stream_mid", Stream_mid_row, (re.row != m_h - 1));
               end
               outstanding = 1;
            end else if (Done_1row && outstanding) begin
               outstanding = 0;
               last_done_cyc = cyc;
            end
            if (busy) begin
               check_eq("stream_onehot", Stream_mid_row + Stream_last_row, 1);
               check_eq("oc_stable", b_counter_output, cur_oc);
               if (m_h == 1) check_eq("h1_last_row", Stream_last_row, 1);
            end else begin
               check_eq("idle_strobes_low",
                        {Load_kernel_reg, row_start, Stream_mid_row, Stream_last_row, last_channel}, 0);
            end
            if (layer_done) begin
               n_done++;
               check_eq("done_needs_idle", prev_idle, 1);
               check_eq("done_loads_left", exp_k.size(), 0);
               check_eq("done_rows_left", exp_r.size(), 0);
               if (lat_en) check_eq("done_latency", cyc - last_done_cyc, 3);
            end
            prev_pe   = PE_ready;
            prev_idle = PE_with_buffers_IDLE;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic set_modes(input int kd, input int pd, input int id, input int dd,
                            input bit pr, input bit ir, input bit sp, input bit le);
      @(negedge clk); #1;
      kdelay = kd; pe_delay = pd; idle_delay = id; done_delay = dd;
      pe_rand = pr; idle_rand = ir; spur_en = sp; lat_en = le;
      kernel_ready = 1'b1; PE_ready = 1'b1; PE_with_buffers_IDLE = 1'b1;
   endtask

   task automatic begin_layer(input int h, input int ci, input int co);
      @(posedge clk); #1;
      exp_k.delete(); exp_r.delete(); load_oc_log.delete();
      for (int o = 0; o < co; o++)
         for (int i = 0; i < ci; i++) begin
            exp_k.push_back('{oc: o, ic: i});
            for (int r = 0; r < h; r++) exp_r.push_back('{oc: o, ic: i, row: r});
         end
      m_h = h; m_ci = ci; m_co = co;
      n_loads = 0; n_rows = 0; n_done = 0; n_err = 0; busy_cnt = 0;
      first_load = 1; cur_oc = 0;
      cfg_height = DW'(h); cfg_in_ch = CW'(ci); cfg_out_ch = CW'(co);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("start_to_load", Load_kernel_reg, 1);
      check_eq("start_busy", busy, 1);
      check_eq("start_clears_perf", busy_cycles, 0);
      // scramble cfg mid-layer and poke start while busy: both must be ignored
      cfg_height = DW'($urandom_range(0, 7)); cfg_in_ch = CW'($urandom_range(0, 3));
      cfg_out_ch = CW'($urandom_range(0, 3));
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic finish_layer(input string tag, input int budget);
      int i;
      for (i = 0; i < budget && n_done == 0; i++) @(negedge clk);
      check_eq({tag, "_layer_done"}, n_done, 1);
      repeat (3) @(negedge clk);
      check_eq({tag, "_single_done"}, n_done, 1);
      check_eq({tag, "_loads"}, n_loads, m_co * m_ci);
      check_eq({tag, "_rows"}, n_rows, m_co * m_ci * m_h);
      check_eq({tag, "_no_cfg_error"}, n_err, 0);
      check_eq({tag, "_busy_low"}, busy, 0);
`ifdef CONV_SEQ_PERF_EN
      check_eq({tag, "_busy_cycles"}, busy_cycles, busy_cnt);
`else
      check_eq({tag, "_busy_cycles_tied"}, busy_cycles, 0);
`endif
      if (n_done == 0) begin
         @(posedge clk); #2; Reset = 1'b0;
         repeat (2) @(posedge clk); #2; Reset = 1'b1;
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int hh, cc, oo;
      #2;
      check_eq("rst_strobes", {Load_kernel_reg, row_start, Stream_mid_row, Stream_last_row,
                               last_channel, busy, layer_done, cfg_error}, 0);
      check_eq("rst_oc", b_counter_output, 0);
      check_eq("rst_perf", busy_cycles, 0);
      repeat (3) @(posedge clk); #2; Reset = 1'b1;

      // H=3 CI=2 CO=2, all handshakes high, Done_1row 4 cycles after row_start
      set_modes(0, 0, 0, 4, 0, 0, 0, 1);
      begin_layer(3, 2, 2);
      finish_layer("t1", 2000);
      check_eq("t1_loads_lit", n_loads, 4);
      check_eq("t1_rows_lit", n_rows, 12);
      check_eq("t1_oc_log_len", load_oc_log.size(), 4);
      if (load_oc_log.size() == 4) begin
         check_eq("t1_oc_seq0", load_oc_log[0], 0);
         check_eq("t1_oc_seq1", load_oc_log[1], 0);
         check_eq("t1_oc_seq2", load_oc_log[2], 1);
         check_eq("t1_oc_seq3", load_oc_log[3], 1);
      end

      // H=1 CI=1 CO=1
      begin_layer(1, 1, 1);
      finish_layer("t2", 500);
      check_eq("t2_loads_lit", n_loads, 1);
      check_eq("t2_rows_lit", n_rows, 1);

      // rejected starts: each zero dimension
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_loads = 0;
         cfg_height = (k == 0) ? DW'(0) : DW'(2);
         cfg_in_ch  = (k == 1) ? CW'(0) : CW'(2);
         cfg_out_ch = (k == 2) ? CW'(0) : CW'(2);
         start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
         check_eq("cfg_err_pulse", cfg_error, 1);
         check_eq("cfg_err_busy", busy, 0);
         check_eq("cfg_err_no_load", Load_kernel_reg, 0);
         @(posedge clk); #1;
         check_eq("cfg_err_one_cycle", cfg_error, 0);
         check_eq("cfg_err_still_idle", busy, 0);
         check_eq("cfg_err_loads", n_loads, 0);
      end

      // slow handshakes plus spurious Done_1row in WAIT_K
      set_modes(10, 5, 20, 3, 0, 0, 1, 0);
      begin_layer(2, 2, 2);
      finish_layer("t4", 3000);

      // reset during the second row of the first layer
      set_modes(0, 0, 0, 4, 0, 0, 0, 0);
      begin_layer(3, 2, 2);
      for (int i = 0; i < 200 && n_rows < 2; i++) @(negedge clk);
      check_eq("t5_reached_row2", n_rows, 2);
      @(posedge clk); #3; Reset = 1'b0; #1;
      check_eq("t5_async_strobes", {Load_kernel_reg, row_start, Stream_mid_row, Stream_last_row,
                                    last_channel, busy, layer_done, cfg_error}, 0);
      check_eq("t5_async_oc", b_counter_output, 0);
      check_eq("t5_async_perf", busy_cycles, 0);
      check_eq("t5_no_done", n_done, 0);
      repeat (2) @(posedge clk); #2; Reset = 1'b1;
      begin_layer(3, 2, 2);
      finish_layer("t5", 2000);

      // randomized layers and handshakes
      for (int t = 0; t < 8; t++) begin
         hh = $urandom_range(1, 5); cc = $urandom_range(1, 3); oo = $urandom_range(1, 3);
         set_modes($urandom_range(0, 4), 0, 0, $urandom_range(1, 5), 1, 1, 0, 0);
         begin_layer(hh, cc, oo);
         finish_layer("rnd", 4000);
      end

      // busy-cycle counter: H=2 CI=1 CO=1, handshakes high, Done_1row 1 cycle after row_start
      set_modes(0, 0, 0, 1, 0, 0, 0, 0);
      begin_layer(2, 1, 1);
      finish_layer("perf1", 500);
      check_eq("perf1_busy_len_lit", busy_cnt, 10);
      begin_layer(2, 1, 1);
      finish_layer("perf2", 500);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
